// File: rtl/lsu_ctrl_if.sv
// Data-bus port of the LSU: a valid/ready request channel plus a response channel that
// is always accepted. The LSU drives through the master modport, the memory through slave.
interface lsu_ctrl_if #(
  parameter int unsigned ADDR_W = 64
) ();
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_wen;
  logic [7:0]        req_wstrb;
  logic [63:0]       req_wdata;
  logic              resp_valid;
  logic [63:0]       resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_addr, req_wen, req_wstrb, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_addr, req_wen, req_wstrb, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: one outstanding doubleword bus access per op, with pipeline stall,
// flush-kill and WAIT timeout. Define LSU_MISALIGN_CHECK_EN to fault misaligned accesses.
module lsu_ctrl #(
  parameter int unsigned ADDR_W      = 64,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        load_type,
  input  logic [1:0]        store_type,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [63:0]       mem_wdata,
  input  logic              flush,
  output logic              lsu_stall,
  output logic              lsu_done,
  output logic [63:0]       lsu_rdata,
  output logic              lsu_err,
  lsu_ctrl_if.master        bus
);

  localparam int unsigned CntW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [63:0]       wdata_q, wdata_d;
  logic [7:0]        wstrb_q, wstrb_d;
  logic [2:0]        ltype_q, ltype_d;
  logic              wen_q, wen_d;
  logic              kill_q, kill_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [63:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic        start;
  logic [1:0]  size;
  logic [2:0]  off;
  logic [7:0]  strb_base;
  logic [63:0] ld_shift;
  logic [63:0] ld_ext;
  logic        misalign;
  logic        timeout;

  assign start   = (state_q == StIdle) & (mem_read | mem_write) & ~flush;
  assign size    = mem_write ? store_type : load_type[1:0];
  assign off     = mem_addr[2:0];
  assign timeout = (cnt_q == CntW'(TIMEOUT_CYC - 1));

  always_comb begin
    strb_base = 8'h01;
    unique case (size)
      2'd0: strb_base = 8'h01;
      2'd1: strb_base = 8'h03;
      2'd2: strb_base = 8'h0F;
      2'd3: strb_base = 8'hFF;
    endcase
  end

`ifdef LSU_MISALIGN_CHECK_EN
  always_comb begin
    misalign = 1'b0;
    unique case (size)
      2'd0: misalign = 1'b0;
      2'd1: misalign = off[0];
      2'd2: misalign = |off[1:0];
      2'd3: misalign = |off;
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

  // Bring the addressed lane down to bit 0, then extend by access width and signedness.
  assign ld_shift = bus.resp_rdata >> {addr_q[2:0], 3'b000};

  always_comb begin
    ld_ext = ld_shift;
    case (ltype_q)
      3'b000:  ld_ext = {{56{ld_shift[7]}}, ld_shift[7:0]};
      3'b001:  ld_ext = {{48{ld_shift[15]}}, ld_shift[15:0]};
      3'b010:  ld_ext = {{32{ld_shift[31]}}, ld_shift[31:0]};
      3'b100:  ld_ext = {56'd0, ld_shift[7:0]};
      3'b101:  ld_ext = {48'd0, ld_shift[15:0]};
      3'b110:  ld_ext = {32'd0, ld_shift[31:0]};
      default: ld_ext = ld_shift;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    ltype_d   = ltype_q;
    wen_d     = wen_q;
    kill_d    = kill_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    lsu_stall = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          lsu_stall = 1'b1;
          addr_d    = mem_addr;
          wen_d     = mem_write;
          ltype_d   = load_type;
          wstrb_d   = strb_base << off;
          wdata_d   = mem_wdata << {off, 3'b000};
          cnt_d     = '0;
          if (misalign) begin
            state_d = StDone;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d = StReq;
          end
        end
      end
      StReq: begin
        // Once killed, stall only holds back a newly presented op.
        lsu_stall = ~kill_q | mem_read | mem_write;
        if (flush) kill_d = 1'b1;
        if (bus.req_ready) state_d = StWait;
      end
      StWait: begin
        lsu_stall = ~kill_q | mem_read | mem_write;
        if (flush) kill_d = 1'b1;
        if (bus.resp_valid || timeout) begin
          if (kill_q || flush) begin
            state_d = StIdle;
            kill_d  = 1'b0;
          end else begin
            state_d = StDone;
            err_d   = bus.resp_valid ? bus.resp_err : 1'b1;
            rdata_d = (bus.resp_valid && !wen_q) ? ld_ext : 64'd0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      ltype_q <= '0;
      wen_q   <= 1'b0;
      kill_q  <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      ltype_q <= ltype_d;
      wen_q   <= wen_d;
      kill_q  <= kill_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign lsu_done      = (state_q == StDone);
  assign lsu_rdata     = rdata_q;
  assign lsu_err       = err_q;
  assign bus.req_valid = (state_q == StReq);
  assign bus.req_addr  = {addr_q[ADDR_W-1:3], 3'b000};
  assign bus.req_wen   = wen_q;
  assign bus.req_wstrb = wstrb_q;
  assign bus.req_wdata = wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: a driver issues ops, a bus model checks requests and queues
// expected completions, and a monitor checks every lsu_done against that queue.
module tb_lsu_ctrl;

  localparam int unsigned TO = 256;

  typedef struct {
    logic [63:0] addr;
    logic        wen;
    logic [2:0]  lt;
    logic [2:0]  off;
    logic [7:0]  strb;
    logic [63:0] wdata;
  } req_t;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    bit          chk;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  load_type = '0;
  logic [1:0]  store_type = '0;
  logic [63:0] mem_addr = '0;
  logic [63:0] mem_wdata = '0;
  logic        flush = 1'b0;
  logic        lsu_stall, lsu_done, lsu_err;
  logic [63:0] lsu_rdata;

  int n_checks = 0;
  int n_err = 0;

  req_t req_q[$];
  exp_t exp_q[$];

  int          cfg_ready_dly = 0;
  int          cfg_resp_dly = 0;
  logic [63:0] cfg_rdata = '0;
  bit          cfg_err = 1'b0;
  bit          cfg_no_resp = 1'b0;
  int          discard_n = 0;

  logic [63:0] last_addr, last_wdata;
  logic [7:0]  last_strb;
  logic        last_wen;

  lsu_ctrl_if #(.ADDR_W(64)) bus ();

  lsu_ctrl #(.ADDR_W(64), .TIMEOUT_CYC(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .load_type  (load_type),
    .store_type (store_type),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .flush      (flush),
    .lsu_stall  (lsu_stall),
    .lsu_done   (lsu_done),
    .lsu_rdata  (lsu_rdata),
    .lsu_err    (lsu_err),
    .bus        (bus.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic logic [63:0] model_load(input logic [2:0] lt, input logic [2:0] off,
                                             input logic [63:0] d);
    logic [63:0] v, m;
    int nb;
    v  = d >> (8 * int'(off));
    nb = 8 << lt[1:0];
    if (nb == 64) return v;
    m = (64'd1 << nb) - 64'd1;
    v = v & m;
    if (!lt[2] && v[nb-1]) v = v | ~m;
    return v;
  endfunction

  function automatic logic [7:0] model_strb(input logic [1:0] sz, input logic [2:0] off);
    logic [15:0] s;
    s = ((16'd1 << (1 << sz)) - 16'd1) << off;
    return s[7:0];
  endfunction

  function automatic bit model_mis(input bit st_op, input logic [2:0] lt, input logic [1:0] stt,
                                   input logic [2:0] off);
    int nb;
    nb = 1 << (st_op ? stt : lt[1:0]);
    return (int'(off) % nb) != 0;
  endfunction

  // Memory side: holds ready low for a while, checks the request, answers after a delay.
  initial begin : bus_model
    int rdly, pdly;
    logic [63:0] d;
    bit e, nr, disc;
    req_t r;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_rdata = '0;
    bus.resp_err   = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && bus.req_valid) begin
        rdly = cfg_ready_dly;
        pdly = cfg_resp_dly;
        d    = cfg_rdata;
        e    = cfg_err;
        nr   = cfg_no_resp;
        for (int i = 0; i < rdly; i++) begin
          @(negedge clk);
          check("req_valid_held", {63'd0, bus.req_valid}, 64'd1);
        end
        bus.req_ready = 1'b1;
        last_addr  = bus.req_addr;
        last_wdata = bus.req_wdata;
        last_strb  = bus.req_wstrb;
        last_wen   = bus.req_wen;
        if (req_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_req: actual=addr 0x%0h required=no request", bus.req_addr);
          r = '{addr: '0, wen: 1'b0, lt: 3'b011, off: 3'd0, strb: '0, wdata: '0};
        end else begin
          r = req_q.pop_front();
          check("req_addr", bus.req_addr, r.addr);
          check("req_wen", {63'd0, bus.req_wen}, {63'd0, r.wen});
          if (r.wen) begin
            check("req_wstrb", {56'd0, bus.req_wstrb}, {56'd0, r.strb});
            check("req_wdata", bus.req_wdata, r.wdata);
          end
        end
        @(negedge clk);
        bus.req_ready = 1'b0;
        disc = (discard_n > 0);
        if (disc) discard_n--;
        if (nr) begin
          if (!disc) exp_q.push_back('{rdata: 64'd0, err: 1'b1, chk: 1'b0});
        end else begin
          repeat (pdly) @(negedge clk);
          bus.resp_valid = 1'b1;
          bus.resp_rdata = d;
          bus.resp_err   = e;
          if (!disc)
            exp_q.push_back('{rdata: r.wen ? 64'd0 : model_load(r.lt, r.off, d), err: e, chk: 1'b1});
          @(negedge clk);
          bus.resp_valid = 1'b0;
          bus.resp_err   = 1'b0;
        end
      end
    end
  end

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      if (!rst && lsu_done) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_done: actual=done rdata 0x%0h required=no completion",
                   lsu_rdata);
        end else begin
          x = exp_q.pop_front();
          check("done_err", {63'd0, lsu_err}, {63'd0, x.err});
          if (x.chk) check("done_rdata", lsu_rdata, x.rdata);
        end
      end
    end
  end

  task automatic run_op(input bit st_op, input logic [2:0] lt, input logic [1:0] stt,
                        input logic [63:0] a, input logic [63:0] w, output int ncyc);
    req_t r;
    bit mis;
    mis = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
    mis = model_mis(st_op, lt, stt, a[2:0]);
`endif
    r = '{addr: a & ~64'h7, wen: st_op, lt: lt, off: a[2:0], strb: model_strb(stt, a[2:0]),
          wdata: w << (8 * int'(a[2:0]))};
    if (mis) exp_q.push_back('{rdata: 64'd0, err: 1'b1, chk: 1'b1});
    else req_q.push_back(r);
    mem_read   = !st_op;
    mem_write  = st_op;
    load_type  = lt;
    store_type = stt;
    mem_addr   = a;
    mem_wdata  = w;
    ncyc = 0;
    #1;
    while (lsu_stall && ncyc < 2000) begin
      @(negedge clk);
      ncyc++;
    end
    if (lsu_stall) begin
      n_checks++;
      n_err++;
      $display("FAIL op_complete: actual=still stalled required=stall release");
    end
    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);
  endtask

  task automatic reset_check(input string tag);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check({tag, "_ctl"}, {59'd0, lsu_stall, lsu_done, lsu_err, bus.req_valid, bus.req_wen},
          64'd0);
    check({tag, "_rdata"}, lsu_rdata, 64'd0);
    check({tag, "_wstrb"}, {56'd0, bus.req_wstrb}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: actual=no finish required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    int n, hs;
    logic [63:0] saved;
    bit rd_changed;
    bit st;
    reset_check("reset");

    // Doubleword load, fastest bus.
    cfg_rdata = 64'h1122334455667788;
    run_op(1'b0, 3'b011, 2'd0, 64'h80000008, 64'd0, n);
    check("ld_latency", n, 3);
    check("ld_rdata", lsu_rdata, 64'h1122334455667788);

    cfg_rdata = 64'h0000000080FF0000;
    run_op(1'b0, 3'b000, 2'd0, 64'h80000003, 64'd0, n);
    check("lb_rdata", lsu_rdata, 64'hFFFFFFFFFFFFFF80);
    run_op(1'b0, 3'b100, 2'd0, 64'h80000003, 64'd0, n);
    check("lbu_rdata", lsu_rdata, 64'h80);
    run_op(1'b0, 3'b000, 2'd0, 64'h80000002, 64'd0, n);
    check("lb_lane2", lsu_rdata, 64'hFFFFFFFFFFFFFFFF);

    run_op(1'b1, 3'd0, 2'd1, 64'h80000006, 64'hABCD, n);
    check("sh_wstrb", {56'd0, last_strb}, 64'hC0);
    check("sh_wdata", last_wdata, 64'hABCD000000000000);
    check("sh_addr", last_addr, 64'h80000000);
    check("sh_wen", {63'd0, last_wen}, 64'd1);
    check("sh_rdata", lsu_rdata, 64'd0);

    // Misaligned word load.
    cfg_rdata = 64'h1111876543212222;
    run_op(1'b0, 3'b010, 2'd0, 64'h80000002, 64'd0, n);
`ifdef LSU_MISALIGN_CHECK_EN
    check("mis_latency", n, 1);
    check("mis_rdata", lsu_rdata, 64'd0);
`else
    check("mis_latency", n, 3);
    check("mis_rdata", lsu_rdata, 64'hFFFFFFFF87654321);
`endif

    // Bus error.
    cfg_err = 1'b1;
    cfg_rdata = 64'hCAFE_F00D_1234_5678;
    run_op(1'b0, 3'b110, 2'd0, 64'h80000004, 64'd0, n);
    cfg_err = 1'b0;
    check("err_rdata", lsu_rdata, 64'h00000000CAFEF00D);

    // No response: timeout.
    cfg_no_resp = 1'b1;
    run_op(1'b0, 3'b011, 2'd0, 64'h80000010, 64'd0, n);
    cfg_no_resp = 1'b0;
    check("timeout_latency", n, TO + 2);
    check("timeout_err", {63'd0, lsu_err}, 64'd1);

    // Slow ready, flush in WAIT, then a new LW held behind the draining response.
    discard_n     = 1;
    cfg_ready_dly = 5;
    cfg_resp_dly  = 6;
    cfg_rdata     = 64'hDEAD_BEEF_0BAD_F00D;
    req_q.push_back('{addr: 64'h80000020, wen: 1'b0, lt: 3'b011, off: 3'd0, strb: 8'hFF,
                      wdata: 64'd0});
    mem_read  = 1'b1;
    load_type = 3'b011;
    mem_addr  = 64'h80000020;
    hs = 0;
    while (!(bus.req_valid && bus.req_ready) && hs < 50) begin
      @(negedge clk);
      #1;
      hs++;
    end
    check("flush_hs_seen", {63'd0, bus.req_valid & bus.req_ready}, 64'd1);
    @(negedge clk);
    flush    = 1'b1;
    mem_read = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_stall_drop", {63'd0, lsu_stall}, 64'd0);
    saved         = lsu_rdata;
    rd_changed    = 1'b0;
    cfg_ready_dly = 0;
    cfg_resp_dly  = 0;
    cfg_rdata     = 64'h0123_4567_89AB_CDEF;
    req_q.push_back('{addr: 64'h80000030, wen: 1'b0, lt: 3'b010, off: 3'd4, strb: 8'hF0,
                      wdata: 64'd0});
    mem_read  = 1'b1;
    load_type = 3'b010;
    mem_addr  = 64'h80000034;
    #1;
    check("kill_stall_new_op", {63'd0, lsu_stall}, 64'd1);
    n = 0;
    while (lsu_stall && n < 100) begin
      @(negedge clk);
      n++;
      if (lsu_stall && lsu_rdata !== saved) rd_changed = 1'b1;
    end
    mem_read = 1'b0;
    @(negedge clk);
    check("kill_rdata_kept", {63'd0, rd_changed}, 64'd0);
    check("kill_lw_latency", n, 9);
    check("kill_lw_rdata", lsu_rdata, 64'h0000000001234567);

    // Randomized traffic.
    for (int k = 0; k < 150; k++) begin
      cfg_ready_dly = int'($urandom_range(0, 3));
      cfg_resp_dly  = int'($urandom_range(0, 3));
      cfg_err       = ($urandom_range(0, 7) == 0);
      cfg_rdata     = {$urandom, $urandom};
      st = $urandom_range(0, 1) == 1;
      run_op(st, 3'($urandom_range(0, 6)), 2'($urandom_range(0, 3)),
             64'h80000000 | 64'($urandom_range(0, 4095)), {$urandom, $urandom}, n);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    cfg_err = 1'b0;

    repeat (5) @(negedge clk);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    check("req_q_drained", 64'(req_q.size()), 64'd0);
    reset_check("end_reset");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
